ram_param: RTL and testbench

- Parametrised single-clock RAM: one write port and one read port, configurable data width, depth and read latency.
- Adds a hardware clear sequencer, because the async reset cannot zero the array.
- Zeroes the array after reset or on request.
- Drop-in memory for data RAM, screen buffer and similar stores in the CPU/platform design.
- With default parameters it reproduces the 4K x 16 memory map once initialisation has completed.

---
 rtl/ram_pkg.sv | 14 +
 rtl/ram_init_seq.sv | 50 +++++
 rtl/ram_param.sv | 88 ++++++++
 tb/tb_ram_param.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and sizing helpers for the parametrised RAM and its clear sequencer.
package ram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  // Pointer/index width for a given depth; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_init_seq.sv
// Zeroing sweep sequencer: one word per cycle from 0 to DEPTH-1, restartable by clear.
// busy is high for exactly DEPTH cycles after reset release or a clear edge.
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int PW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  output logic          sweep_we_o,
  output logic [PW-1:0] sweep_addr_o,
  output logic          ready_o,
  output logic          busy_o
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  state_t        state_q;
  logic [PW-1:0] ptr_q;
  logic          busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else if (clear_i) begin
      state_q <= INIT;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else if (state_q == INIT) begin
      if (ptr_q == LAST) begin
        state_q <= READY;
        ptr_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        ptr_q <= ptr_q + 1'b1;
      end
    end
  end

  // A clear arriving mid-sweep restarts from 0 without writing on that edge.
  assign sweep_we_o   = (state_q == INIT) && !clear_i;
  assign sweep_addr_o = ptr_q;
  assign ready_o      = (state_q == READY);
  assign busy_o       = busy_q;

endmodule

// File: rtl/ram_param.sv
// Single-clock RAM, one write and one read port, combinational or 1-cycle registered read.
// No backpressure; reads and writes accepted every cycle once the zeroing sweep is done.
module ram_param
  import ram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4096,
  parameter int RD_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  input  logic              rd_en,
  input  logic              clear,
  output logic [DATA_W-1:0] out,
  output logic              rd_valid,
  output logic              busy
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic          sweep_we;
  logic [PW-1:0] sweep_addr;
  logic          ready;
  logic          in_range;
  logic [PW-1:0] idx;
  logic [DATA_W-1:0] rd_word;

  ram_init_seq #(
    .DEPTH (DEPTH)
  ) u_seq (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (clear),
    .sweep_we_o   (sweep_we),
    .sweep_addr_o (sweep_addr),
    .ready_o      (ready),
    .busy_o       (busy)
  );

  // Range check on the full address first, so upper bits can never alias into the array.
  assign in_range = ({1'b0, address} < DEPTH_A);
  assign idx      = address[PW-1:0];
  assign rd_word  = in_range ? mem[idx] : '0;

  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_addr] <= '0;
    end else if (ready && load && in_range) begin
      mem[idx] <= in;
    end
  end

  if (RD_REG != 0) begin : g_rd_reg
    logic [DATA_W-1:0] out_q;
    logic              rd_valid_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out_q      <= '0;
        rd_valid_q <= 1'b0;
      end else if (!ready || clear) begin
        out_q      <= '0;
        rd_valid_q <= 1'b0;
      end else if (rd_en) begin
        out_q      <= rd_word;
        rd_valid_q <= 1'b1;
      end else begin
        rd_valid_q <= 1'b0;
      end
    end

    assign out      = out_q;
    assign rd_valid = rd_valid_q;
  end else begin : g_rd_comb
    logic unused_rd_en;
    assign unused_rd_en = rd_en;
    assign out          = ready ? rd_word : '0;
    assign rd_valid     = ~busy;
  end

endmodule

// File: tb/tb_ram_param.sv
// Directed bench: default 4Kx16 comb-read RAM, a 256-word registered-read RAM and a 1000-word RAM.
module tb_ram_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [15:0] in0, a0, out0;  logic ld0, re0, cl0, rv0, bz0;
  logic [15:0] in1, a1, out1;  logic ld1, re1, cl1, rv1, bz1;
  logic [15:0] in2, a2, out2;  logic ld2, re2, cl2, rv2, bz2;

  ram_param u0 (
    .clk(clk), .reset(reset), .in(in0), .address(a0), .load(ld0), .rd_en(re0),
    .clear(cl0), .out(out0), .rd_valid(rv0), .busy(bz0)
  );

  ram_param #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .RD_REG(1)) u1 (
    .clk(clk), .reset(reset), .in(in1), .address(a1), .load(ld1), .rd_en(re1),
    .clear(cl1), .out(out1), .rd_valid(rv1), .busy(bz1)
  );

  ram_param #(.DATA_W(16), .ADDR_W(16), .DEPTH(1000), .RD_REG(0)) u2 (
    .clk(clk), .reset(reset), .in(in2), .address(a2), .load(ld2), .rd_en(re2),
    .clear(cl2), .out(out2), .rd_valid(rv2), .busy(bz2)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy1(output int n);
    n = 0;
    for (int c = 1; c <= 2000; c++) begin
      tick();
      if (!bz1) begin
        n = c;
        break;
      end
    end
  endtask

  initial begin
    int n0, n1, n2;
    reset = 1'b1;
    {in0, a0, ld0, re0, cl0} = '0;
    {in1, a1, ld1, re1, cl1} = '0;
    {in2, a2, ld2, re2, cl2} = '0;
    repeat (3) tick();

    chk("rst_busy0", bz0, 1);
    chk("rst_rv0", rv0, 0);
    chk("rst_out0", out0, 0);
    chk("rst_busy1", bz1, 1);
    chk("rst_rv1", rv1, 0);
    chk("rst_out1", out1, 0);

    // Sweep lengths measured from reset release
    reset = 1'b0;
    n0 = 0; n1 = 0; n2 = 0;
    for (int c = 1; c <= 5000; c++) begin
      tick();
      if (!bz0 && n0 == 0) n0 = c;
      if (!bz1 && n1 == 0) n1 = c;
      if (!bz2 && n2 == 0) n2 = c;
      if (n0 != 0 && n1 != 0 && n2 != 0) break;
    end
    chk("sweep_len0", n0, 4096);
    chk("sweep_len1", n1, 256);
    chk("sweep_len2", n2, 1000);

    // u0: combinational read, default map
    a0 = 16'd4095; #1;
    chk("u0_rd4095", out0, 16'h0000);
    chk("u0_rv_ready", rv0, 1);
    a0 = 16'h0123; in0 = 16'hBEEF; ld0 = 1'b1; #1;
    chk("u0_wr_old", out0, 16'h0000);
    tick(); ld0 = 1'b0; #1;
    chk("u0_wr_new", out0, 16'hBEEF);
    a0 = 16'h0000; in0 = 16'h0001; ld0 = 1'b1;
    tick(); ld0 = 1'b0;
    a0 = 16'h0123; #1;
    chk("u0_rd123", out0, 16'hBEEF);
    a0 = 16'h0000; #1;
    chk("u0_rd0", out0, 16'h0001);

    // u1: registered read, read-first
    a1 = 16'd5; in1 = 16'h1234; ld1 = 1'b1; re1 = 1'b1;
    tick(); ld1 = 1'b0; re1 = 1'b0;
    chk("u1_rdfirst_out", out1, 16'h0000);
    chk("u1_rdfirst_rv", rv1, 1);
    re1 = 1'b1;
    tick(); re1 = 1'b0;
    chk("u1_rd5_out", out1, 16'h1234);
    chk("u1_rd5_rv", rv1, 1);
    tick();
    chk("u1_idle_rv", rv1, 0);
    chk("u1_idle_hold", out1, 16'h1234);
    a1 = 16'd300; re1 = 1'b1;
    tick(); re1 = 1'b0;
    chk("u1_oor_out", out1, 16'h0000);
    chk("u1_oor_rv", rv1, 1);
    a1 = 16'd6; in1 = 16'h6666; ld1 = 1'b1;
    tick(); ld1 = 1'b0;
    a1 = 16'd5; re1 = 1'b1;
    tick();
    chk("u1_b2b_a", out1, 16'h1234);
    a1 = 16'd6;
    tick(); re1 = 1'b0;
    chk("u1_b2b_b", out1, 16'h6666);
    chk("u1_b2b_rv", rv1, 1);

    // u2: out-of-range and alias writes must be dropped
    a2 = 16'd1000; in2 = 16'hAAAA; ld2 = 1'b1;
    tick();
    a2 = 16'd1024;
    tick(); ld2 = 1'b0;
    a2 = 16'd1000; #1;
    chk("u2_oor_rd", out2, 16'h0000);
    a2 = 16'd0; #1;
    chk("u2_alias0", out2, 16'h0000);
    a2 = 16'd999; in2 = 16'h1357; ld2 = 1'b1;
    tick(); ld2 = 1'b0;
    chk("u2_rd999", out2, 16'h1357);

    // u2: clear in READY after filling 0..7
    for (int i = 0; i < 8; i++) begin
      a2 = 16'(i); in2 = 16'hFFFF; ld2 = 1'b1;
      tick();
    end
    ld2 = 1'b0; a2 = 16'd7; #1;
    chk("u2_fill7", out2, 16'hFFFF);
    cl2 = 1'b1;
    tick(); cl2 = 1'b0;
    chk("u2_clr_busy", bz2, 1);
    a2 = 16'd2; #1;
    chk("u2_init_out", out2, 16'h0000);
    chk("u2_init_rv", rv2, 0);
    n2 = 0;
    for (int c = 1; c <= 2000; c++) begin
      if (c == 500) begin
        a2 = 16'd3; in2 = 16'h7777; ld2 = 1'b1;
      end
      tick();
      ld2 = 1'b0;
      if (!bz2) begin
        n2 = c;
        break;
      end
    end
    chk("u2_clr_len", n2, 1000);
    for (int i = 0; i < 8; i++) begin
      a2 = 16'(i); #1;
      chk($sformatf("u2_cleared_%0d", i), out2, 16'h0000);
    end

    // u1: reset mid-read clears a pending rd_valid at once
    a1 = 16'd5; re1 = 1'b1;
    tick();
    chk("u1_pre_rst_rv", rv1, 1);
    reset = 1'b1; #1;
    chk("u1_rst_rd_rv", rv1, 0);
    chk("u1_rst_rd_out", out1, 16'h0000);
    chk("u1_rst_rd_busy", bz1, 1);
    tick(); reset = 1'b0;

    // u1: reset at sweep cycle 100 with rd_en held
    repeat (100) tick();
    reset = 1'b1; #1;
    chk("u1_rst_sw_busy", bz1, 1);
    chk("u1_rst_sw_rv", rv1, 0);
    chk("u1_rst_sw_out", out1, 16'h0000);
    tick(); reset = 1'b0;
    count_busy1(n1);
    chk("u1_resweep_len", n1, 256);
    re1 = 1'b0;

    // u1: clear during the sweep restarts a full-length sweep
    cl1 = 1'b1;
    tick(); cl1 = 1'b0;
    repeat (50) tick();
    cl1 = 1'b1;
    tick(); cl1 = 1'b0;
    count_busy1(n1);
    chk("u1_restart_len", n1, 256);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
